uart_word_tx: RTL and testbench

- Parametrised successor to the DRAM-read-to-UART transmit path.
- Accepts DATA_W-bit words from the read-side FIFO over a valid/ready handshake and holds one pending word while another is being sent.
- Splits each word into bytes in a configurable byte order and transmits them as UART frames.
- Frame format is configurable: baud divisor, optional parity, 1 or 2 stop bits.
- Single clock domain; sits directly after the FIFO read FSM, replacing the separate byte-shifter, transmitter-FSM and UART-TX blocks.

---
 rtl/uart_word_tx.sv | 159 +++++++++++++++
 tb/tb_uart_word_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// Word-to-UART transmitter: takes DATA_W-bit words over valid/ready, holds one
// pending word, and sends its bytes back to back as configurable UART frames.
module uart_word_tx #(
  parameter int DATA_W       = 256,
  parameter int CLKS_PER_BIT = 868,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  localparam int NBYTES      = DATA_W / 8,
  localparam int IDX_W       = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              byte_done,
  output logic              word_done,
  output logic [IDX_W-1:0]  byte_idx
);

  // state  | meaning
  // IDLE   | line high, waiting for a pending word
  // START  | start bit (low)
  // DATA   | 8 data bits, LSB first
  // PARITY | parity bit (only when PARITY != 0)
  // STOP   | STOP_BITS stop bits (high)
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [2:0]        bit_idx_q;
  logic              stop_cnt_q;
  logic [IDX_W-1:0]  byte_idx_q;
  logic [DATA_W-1:0] pend_q;
  logic              pend_valid_q;
  logic [DATA_W-1:0] word_q;

  logic [7:0] cur_byte;
  logic       bit_tick;
  logic       stop_end;
  logic       last_byte;
  logic       par_bit;
  logic       accept;
  logic       load;
  logic       next_byte;

  // The word register shifts toward the transmitted end, so the current byte
  // always sits at a fixed position.
  assign cur_byte  = (MSB_FIRST != 0) ? word_q[DATA_W-1 -: 8] : word_q[7:0];
  assign bit_tick  = (bit_cnt_q == CNT_LAST);
  assign stop_end  = bit_tick && (stop_cnt_q == STOP_LAST);
  assign last_byte = (byte_idx_q == IDX_LAST);
  assign par_bit   = (PARITY == 2) ? ~(^cur_byte) : ^cur_byte;
  assign accept    = in_valid && !pend_valid_q;

  assign in_ready = ~pend_valid_q;
  assign tx_busy  = (state_q != S_IDLE) || pend_valid_q;
  assign byte_idx = byte_idx_q;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    next_byte = 1'b0;
    tx_serial = 1'b1;
    byte_done = 1'b0;
    word_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_serial = 1'b0;
        if (bit_tick) state_d = S_DATA;
      end
      S_DATA: begin
        tx_serial = cur_byte[bit_idx_q];
        if (bit_tick && bit_idx_q == 3'd7) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_serial = par_bit;
        if (bit_tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (stop_end) begin
          byte_done = 1'b1;
          word_done = last_byte;
          if (!last_byte) begin
            next_byte = 1'b1;
            state_d   = S_START;
          end else if (pend_valid_q) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      byte_idx_q   <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE || bit_tick) bit_cnt_q <= '0;
      else                               bit_cnt_q <= bit_cnt_q + 1'b1;

      if (state_q == S_DATA && bit_tick) bit_idx_q <= bit_idx_q + 3'd1;

      if (state_q == S_STOP && bit_tick) stop_cnt_q <= stop_end ? 1'b0 : (stop_cnt_q + 1'b1);

      // accept and load never coincide: accept needs pend_valid_q low, load needs it high
      if (accept) begin
        pend_q       <= in_data;
        pend_valid_q <= 1'b1;
      end else if (load) begin
        pend_valid_q <= 1'b0;
      end

      if (load) begin
        word_q     <= pend_q;
        byte_idx_q <= '0;
      end else if (next_byte) begin
        word_q     <= (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);
        byte_idx_q <= byte_idx_q + 1'b1;
      end else if (state_d == S_IDLE) begin
        byte_idx_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: four configurations share one stimulus thread; a line
// monitor decodes frames and compares them against a scoreboard of expected frames.
module tb_uart_word_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  sel;

  logic ser [4];
  logic rdy [4];
  logic busy [4];
  logic bd [4];
  logic wd [4];
  logic [1:0] idx0, idx1;
  logic       idx2, idx3;

  always #5 clk = ~clk;

  uart_word_tx #(.DATA_W(32), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1)) dut_msb (
    .clk(clk), .rstn(rstn), .in_valid(in_valid && sel == 2'd0), .in_data(in_data),
    .in_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .byte_done(bd[0]),
    .word_done(wd[0]), .byte_idx(idx0));

  uart_word_tx #(.DATA_W(32), .CLKS_PER_BIT(CPB), .MSB_FIRST(0), .PARITY(0), .STOP_BITS(1)) dut_lsb (
    .clk(clk), .rstn(rstn), .in_valid(in_valid && sel == 2'd1), .in_data(in_data),
    .in_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .byte_done(bd[1]),
    .word_done(wd[1]), .byte_idx(idx1));

  uart_word_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .PARITY(1), .STOP_BITS(2)) dut_even (
    .clk(clk), .rstn(rstn), .in_valid(in_valid && sel == 2'd2), .in_data(in_data[7:0]),
    .in_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .byte_done(bd[2]),
    .word_done(wd[2]), .byte_idx(idx2));

  uart_word_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .PARITY(2), .STOP_BITS(2)) dut_odd (
    .clk(clk), .rstn(rstn), .in_valid(in_valid && sel == 2'd3), .in_data(in_data[7:0]),
    .in_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(busy[3]), .byte_done(bd[3]),
    .word_done(wd[3]), .byte_idx(idx3));

  logic       ser_o, rdy_o, busy_o, bd_o, wd_o;
  logic [1:0] idx_o;

  always_comb begin
    ser_o  = ser[sel];
    rdy_o  = rdy[sel];
    busy_o = busy[sel];
    bd_o   = bd[sel];
    wd_o   = wd[sel];
    case (sel)
      2'd0:    idx_o = idx0;
      2'd1:    idx_o = idx1;
      2'd2:    idx_o = {1'b0, idx2};
      default: idx_o = {1'b0, idx3};
    endcase
  end

  int cfg_nb   [4] = '{4, 4, 1, 1};
  int cfg_msb  [4] = '{1, 0, 1, 1};
  int cfg_par  [4] = '{0, 0, 1, 2};
  int cfg_stop [4] = '{1, 1, 2, 2};

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    logic [1:0]  idx;
    logic        wd;
  } frame_t;

  frame_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int nb = cfg_nb[sel];
    for (int k = 0; k < nb; k++) begin
      frame_t f;
      logic [7:0] b;
      if (cfg_msb[sel] != 0) b = 8'(w >> (8 * (nb - 1 - k)));
      else                   b = 8'(w >> (8 * k));
      f.bits = '1;
      f.bits[0] = 1'b0;
      f.bits[8:1] = b;
      if (cfg_par[sel] == 1) f.bits[9] = ^b;
      if (cfg_par[sel] == 2) f.bits[9] = ~(^b);
      f.nbits = 9 + ((cfg_par[sel] != 0) ? 1 : 0) + cfg_stop[sel];
      f.idx = 2'(k);
      f.wd = (k == nb - 1);
      sb.push_back(f);
    end
  endtask

  // Returns with the accept edge just passed (the sample after it is n = 1).
  task automatic send(input logic [31:0] w);
    int k = 0;
    while (rdy_o !== 1'b1 && k < 500) begin
      tick();
      k++;
    end
    chk("ready_timeout", rdy_o, 1);
    in_data  = w;
    in_valid = 1'b1;
    push_word(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_wd(input int start_n, input int limit, output int n);
    n = start_n;
    while (wd_o !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("word_done_timeout", wd_o, 1);
  endtask

  // Line monitor: detects the start bit, samples mid-bit, and checks pulses and
  // byte_idx in the final cycle of the frame.
  initial begin
    bit          mon_active;
    int          mon_cnt;
    logic [11:0] fb;
    logic [11:0] mask;
    frame_t      cur;
    mon_active = 1'b0;
    mon_cnt    = 0;
    fb         = '1;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && ser_o === 1'b0) begin
          if (sb.size() == 0) begin
            chk("unexpected_frame", sb.size(), 1);
          end else begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            cur        = sb[0];
            fb         = '1;
          end
        end else if (mon_active) begin
          mon_cnt++;
        end
        if (mon_active) begin
          if (mon_cnt % CPB == CPB / 2) fb[mon_cnt / CPB] = ser_o;
          if (mon_cnt == cur.nbits * CPB - 1) begin
            mask = (12'h1 << cur.nbits) - 12'h1;
            chk("byte_done", bd_o, 1);
            chk("word_done", wd_o, cur.wd);
            chk("byte_idx", idx_o, cur.idx);
            chk("frame_bits", fb & mask, cur.bits & mask);
            void'(sb.pop_front());
            n_frames++;
            mon_active = 1'b0;
          end else if (bd_o !== 1'b0 || wd_o !== 1'b0) begin
            chk("early_pulse", {bd_o, wd_o}, 0);
          end
        end else if (bd_o !== 1'b0 || wd_o !== 1'b0) begin
          chk("stray_pulse", {bd_o, wd_o}, 0);
        end
      end
    end
  end

  initial begin
    int n;
    int bad;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    sel      = 2'd0;

    // reset values on every configuration
    tick();
    tick();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #0;
      chk("rst_tx_serial", ser_o, 1);
      chk("rst_in_ready", rdy_o, 1);
      chk("rst_tx_busy", busy_o, 0);
      chk("rst_pulses", {bd_o, wd_o}, 0);
      chk("rst_byte_idx", idx_o, 0);
    end
    sel  = 2'd0;
    rstn = 1'b1;
    tick();

    // MSB-first word from idle: latency and total length
    send(32'hA1B2C3D4);
    chk("t1_ready_low", rdy_o, 0);
    chk("t1_line_idle", ser_o, 1);
    chk("t1_busy", busy_o, 1);
    tick();
    chk("t1_start_bit", ser_o, 0);
    chk("t1_ready_back", rdy_o, 1);
    wait_wd(2, 400, n);
    chk("t1_word_latency", n, 161);
    tick();
    chk("t1_line_after", ser_o, 1);
    chk("t1_busy_after", busy_o, 0);

    // no activity while in_valid stays low
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ser_o !== 1'b1 || busy_o !== 1'b0 || bd_o !== 1'b0 || wd_o !== 1'b0 || rdy_o !== 1'b1) bad++;
    end
    chk("idle_hold", bad, 0);

    // LSB-first byte order
    sel = 2'd1;
    tick();
    send(32'hA1B2C3D4);
    wait_wd(1, 400, n);
    chk("t2_word_latency", n, 161);
    tick();

    // even then odd parity, two stop bits, single-byte words
    sel = 2'd2;
    tick();
    send(32'h000000A1);
    wait_wd(1, 200, n);
    chk("t3_even_len", n, 49);
    tick();
    sel = 2'd3;
    tick();
    send(32'h000000A1);
    wait_wd(1, 200, n);
    chk("t3_odd_len", n, 49);
    tick();

    // back-to-back words with in_valid held high
    sel = 2'd0;
    tick();
    in_data  = 32'h11223344;
    in_valid = 1'b1;
    push_word(32'h11223344);
    tick();
    chk("t4_ready_drop", rdy_o, 0);
    in_data = 32'hF00DBEEF;
    push_word(32'hF00DBEEF);
    tick();
    chk("t4_ready_rise", rdy_o, 1);
    tick();
    chk("t4_second_accept", rdy_o, 0);
    in_valid = 1'b0;
    wait_wd(3, 400, n);
    chk("t4_first_latency", n, 161);
    tick();
    chk("t4_no_gap", ser_o, 0);
    chk("t4_ready_after_load", rdy_o, 1);
    wait_wd(1, 400, n);
    chk("t4_second_latency", n, 160);
    tick();

    // reset during a data bit of the second byte
    send(32'h5A3CC3A5);
    n = 1;
    while (n < 55) begin
      tick();
      n++;
    end
    rstn = 1'b0;
    sb.delete();
    tick();
    chk("t5_tx_serial", ser_o, 1);
    chk("t5_in_ready", rdy_o, 1);
    chk("t5_tx_busy", busy_o, 0);
    chk("t5_word_done", wd_o, 0);
    rstn = 1'b1;
    tick();
    send(32'hC0FFEE42);
    wait_wd(1, 400, n);
    chk("t5_word_latency", n, 161);
    tick();
    tick();

    chk("scoreboard_empty", sb.size(), 0);
    chk("frame_count", n_frames, 23);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
